serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//   Bit-serial W-bit subtractor computing D = A - B, LSB first, with one full-subtractor cell.
//   Holds the inter-bit borrow in a flip-flop between cycles.
//   Sits upstream of the full-subtractor cell: it sequences operand bits and the borrow into it,
//   then collects the difference bits into a parallel result.
//   Used where area matters more than latency.
// PARAMETERS
//   W   4   operand/result width in bits (W >= 1); internal counter width is $clog2(W+1)
// PORTS
//   clk    in   1   rising-edge clock
//   rst_n  in   1   asynchronous active-low reset
//   start  in   1   request: sample A/B and begin; accepted only in IDLE
//   A      in   W   minuend, sampled on the accepting edge only
//   B      in   W   subtrahend, sampled on the accepting edge only
//   busy   out  1   high in RUN and DONE; start is ignored while high
//   done   out  1   one-cycle pulse; D/Bout valid from this cycle on
//   D      out  W   difference A-B mod 2^W, held until the next start is accepted
//   Bout   out  1   final borrow: 1 iff A < B (unsigned), held with D
//   ovf    out  1   signed overflow flag (present only with SERSUB_OVF_EN)
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, busy=0, done=0, D=0, Bout=0, ovf=0.
//     Operand shift registers, borrow FF and counter all clear.
//     Applies at any point, including mid-RUN; the in-flight operation is discarded, no done.
//   States: IDLE -> RUN -> DONE -> IDLE.
//   IDLE: on an edge with start=1, load sa<=A, sb<=B, br<=0, cnt<=0, D<=0, go RUN.
//     Otherwise hold all outputs.
//   RUN, each edge:
//     Cell inputs: a=sa[0], b=sb[0], bin=br.
//     d = a^b^bin;  bo = (~a&b) | (~(a^b)&bin).
//     sa, sb shift right one bit. D <= {d, D[W-1:1]}. br <= bo. cnt <= cnt+1.
//     The edge that processes bit W-1 (cnt==W-1) also sets Bout<=bo and moves to DONE.
//   DONE: done=1 for exactly this one cycle, then IDLE.
//     start during DONE is ignored; the earliest accepted restart is the edge after DONE.
//   Latency: start accepted at edge k -> bits processed at edges k+1..k+W -> done high
//     in the cycle following edge k+W. Throughput: one operation per W+2 cycles.
//   A/B changes after the accepting edge have no effect.
//   D and Bout are not updated before done, except the D shift during RUN.
//   W=1: a single RUN cycle, identical to one full-subtractor evaluation.
//   Wrap-around: result is modulo 2^W (e.g. 0-1 gives all ones with Bout=1).
//   All outputs are registered; no combinational path from inputs to outputs.
// CONFIGURATION
//   SERSUB_OVF_EN defined:
//     Adds port ovf, updated together with Bout: ovf <= (sa_msb != sb_msb) && (d_msb != sa_msb).
//     sa_msb and sb_msb are the operand MSBs captured at start.
//     ovf resets to 0 and is held until the next completion.
//   SERSUB_OVF_EN undefined:
//     Port ovf and its logic are absent; all other behaviour is identical.
// TESTING
//   W=4, A=0101, B=0011, pulse start -> done 5 cycles later, D=0010, Bout=0, busy low next cycle.
//   W=4, A=0011, B=0101 -> D=1110, Bout=1; A=0000, B=0001 -> D=1111, Bout=1 (wrap).
//   W=4, A=1111, B=1111 -> D=0000, Bout=0.
//     Then exhaustive 256 pairs checked against (A-B) mod 16 and A<B.
//   start re-asserted during RUN and DONE with different A/B -> ignored; first result unchanged.
//     A start on the cycle after done is accepted.
//   rst_n low for 1 cycle mid-RUN (after 2 bits) -> busy=0, D=0, Bout=0 immediately, no done.
//     A following start computes correctly.
//   SERSUB_OVF_EN, W=4: A=0111, B=1000 -> D=1111, ovf=1.
//     A=0101, B=0011 -> ovf=0. A=1000, B=0001 -> D=0111, ovf=1.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial W-bit subtractor (D = A - B, LSB first) built around one full-subtractor cell.
// Define SERSUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] D,
  output logic         Bout
`ifdef SERSUB_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [W-1:0]  sa_q, sa_d;
  logic [W-1:0]  sb_q, sb_d;
  logic [W-1:0]  d_q, d_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          br_q, br_d;
  logic          bout_q, bout_d;

  logic cell_a, cell_b, cell_d, cell_bo;

  // ---------------- FSM: state register ----------------
  // NOTE: sequential state is written only with non-blocking (<=) so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (cnt_q == LAST) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy = (state_q != S_IDLE);
    done = (state_q == S_DONE);
  end

  // ---------------- full-subtractor cell ----------------
  assign cell_a  = sa_q[0];
  assign cell_b  = sb_q[0];
  assign cell_d  = cell_a ^ cell_b ^ br_q;
  assign cell_bo = (~cell_a & cell_b) | (~(cell_a ^ cell_b) & br_q);

`ifdef SERSUB_OVF_EN
  logic sa_msb_q, sa_msb_d;
  logic sb_msb_q, sb_msb_d;
  logic ovf_q, ovf_d;
`endif

  // ---------------- datapath next-state ----------------
  always_comb begin
    // NOTE: every variable gets a hold default up front, so branches that do not
    // assign it cannot infer a latch.
    sa_d   = sa_q;
    sb_d   = sb_q;
    d_d    = d_q;
    cnt_d  = cnt_q;
    br_d   = br_q;
    bout_d = bout_q;
`ifdef SERSUB_OVF_EN
    sa_msb_d = sa_msb_q;
    sb_msb_d = sb_msb_q;
    ovf_d    = ovf_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          sa_d  = A;
          sb_d  = B;
          br_d  = 1'b0;
          cnt_d = '0;
          d_d   = '0;
`ifdef SERSUB_OVF_EN
          sa_msb_d = A[W-1];
          sb_msb_d = B[W-1];
`endif
        end
      end
      S_RUN: begin
        sa_d       = sa_q >> 1;
        sb_d       = sb_q >> 1;
        d_d        = d_q >> 1;
        d_d[W-1]   = cell_d;
        br_d       = cell_bo;
        cnt_d      = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          bout_d = cell_bo;
`ifdef SERSUB_OVF_EN
          // Signed overflow: operands of differing sign and result sign differs from A.
          ovf_d = (sa_msb_q != sb_msb_q) && (cell_d != sa_msb_q);
`endif
        end
      end
      default: ;
    endcase
  end

  // ---------------- datapath registers ----------------
  // NOTE: this block holds only control/datapath flops (no memory arrays), so all
  // of them take the async reset and an aborted operation leaves no residue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa_q   <= '0;
      sb_q   <= '0;
      d_q    <= '0;
      cnt_q  <= '0;
      br_q   <= 1'b0;
      bout_q <= 1'b0;
    end else begin
      sa_q   <= sa_d;
      sb_q   <= sb_d;
      d_q    <= d_d;
      cnt_q  <= cnt_d;
      br_q   <= br_d;
      bout_q <= bout_d;
    end
  end

`ifdef SERSUB_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa_msb_q <= 1'b0;
      sb_msb_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      sa_msb_q <= sa_msb_d;
      sb_msb_q <= sb_msb_d;
      ovf_q    <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

  assign D    = d_q;
  assign Bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (W=4): directed table, exhaustive sweep,
// ignored-start, and mid-run reset sequences, all scored through an expected-result queue.
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] A, B;
  logic         busy, done;
  logic [W-1:0] D;
  logic         Bout;
`ifdef SERSUB_OVF_EN
  logic         ovf;
`endif

  serial_subtractor #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .D     (D),
    .Bout  (Bout)
`ifdef SERSUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] d;
    logic         bout;
    logic         ovf;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] d;
    logic         bout;
    logic         ovf;
  } vec_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the operands.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   sa_i, sb_i, s;
    e.d    = W'((32'(a) - 32'(b)) & ((1 << W) - 1));
    e.bout = (a < b);
    sa_i   = $signed(a);
    sb_i   = $signed(b);
    s      = sa_i - sb_i;
    e.ovf  = (s > (1 << (W - 1)) - 1) || (s < -(1 << (W - 1)));
    return e;
  endfunction

  task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1;
    A     = a;
    B     = b;
    sb_q.push_back(model(a, b));
  endtask

  // Waits (bounded) for done; optionally drops start and scrambles A/B right after acceptance.
  task automatic wait_done(input string name, input bit drop_start, input int exp_lat);
    int n;
    bit seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (n == 1 && drop_start) begin
        start = 1'b0;
        A     = W'($urandom);
        B     = W'($urandom);
      end
      seen = done;
    end
    if (!seen) check({name, " timeout"}, 32'(seen), 32'd1);
    else       check({name, " latency"}, 32'(n), 32'(exp_lat));
  endtask

  task automatic compare_result(input string name);
    exp_t e;
    if (sb_q.size() == 0) begin
      check({name, " scoreboard empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check({name, " D"}, 32'(D), 32'(e.d));
      check({name, " Bout"}, 32'(Bout), 32'(e.bout));
`ifdef SERSUB_OVF_EN
      check({name, " ovf"}, 32'(ovf), 32'(e.ovf));
`endif
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    bit   saw_done;

    vecs[0] = '{a: 4'b0101, b: 4'b0011, d: 4'b0010, bout: 1'b0, ovf: 1'b0};
    vecs[1] = '{a: 4'b0011, b: 4'b0101, d: 4'b1110, bout: 1'b1, ovf: 1'b0};
    vecs[2] = '{a: 4'b0000, b: 4'b0001, d: 4'b1111, bout: 1'b1, ovf: 1'b0};
    vecs[3] = '{a: 4'b1111, b: 4'b1111, d: 4'b0000, bout: 1'b0, ovf: 1'b0};
    vecs[4] = '{a: 4'b0111, b: 4'b1000, d: 4'b1111, bout: 1'b1, ovf: 1'b1};
    vecs[5] = '{a: 4'b1000, b: 4'b0001, d: 4'b0111, bout: 1'b0, ovf: 1'b1};

    rst_n = 1'b0;
    start = 1'b0;
    A     = '0;
    B     = '0;
    repeat (2) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset D", 32'(D), 32'd0);
    check("reset Bout", 32'(Bout), 32'd0);
`ifdef SERSUB_OVF_EN
    check("reset ovf", 32'(ovf), 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table; each new start lands in the IDLE cycle right after done.
    for (int i = 0; i < 6; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      drive_start(vecs[i].a, vecs[i].b);
      wait_done(nm, 1'b1, W + 1);
      check({nm, " table D"}, 32'(D), 32'(vecs[i].d));
      check({nm, " table Bout"}, 32'(Bout), 32'(vecs[i].bout));
`ifdef SERSUB_OVF_EN
      check({nm, " table ovf"}, 32'(ovf), 32'(vecs[i].ovf));
`endif
      compare_result(nm);
      @(negedge clk);
      check({nm, " busy after done"}, 32'(busy), 32'd0);
      check({nm, " done one cycle"}, 32'(done), 32'd0);
    end

    // Exhaustive sweep against the model.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        drive_start(W'(a), W'(b));
        wait_done($sformatf("exh %0d-%0d", a, b), 1'b1, W + 1);
        compare_result($sformatf("exh %0d-%0d", a, b));
        @(negedge clk);
      end
    end

    // start held high with other operands through RUN and DONE must be ignored.
    drive_start(4'd3, 4'd1);
    @(negedge clk);
    A = 4'd15;
    B = 4'd0;
    wait_done("ignore run", 1'b0, W);
    A = 4'd12;
    B = 4'd0;
    compare_result("ignore run");
    @(negedge clk);
    check("ignore done busy", 32'(busy), 32'd0);
    check("ignore done D held", 32'(D), 32'd2);
    drive_start(4'd9, 4'd4);
    wait_done("restart", 1'b1, W + 1);
    compare_result("restart");
    @(negedge clk);

    // Leave Bout=1 so the reset clearing it is observable.
    drive_start(4'd0, 4'd1);
    wait_done("pre-reset", 1'b1, W + 1);
    compare_result("pre-reset");
    @(negedge clk);

    // Asynchronous reset after two bits of RUN.
    drive_start(4'd10, 4'd3);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrun reset busy", 32'(busy), 32'd0);
    check("midrun reset done", 32'(done), 32'd0);
    check("midrun reset D", 32'(D), 32'd0);
    check("midrun reset Bout", 32'(Bout), 32'd0);
    void'(sb_q.pop_front());
    @(negedge clk);
    rst_n    = 1'b1;
    saw_done = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("midrun no done", 32'(saw_done), 32'd0);
    drive_start(4'd10, 4'd3);
    wait_done("post-reset", 1'b1, W + 1);
    compare_result("post-reset");
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
